// File: rtl/exmem_initiator.sv
// exmem_initiator
//   Bridges a host command/response stream onto a simple pipelined memory
//   bus (strobe out, ack back, fixed but unknown latency, strictly in order).
//   Requests are issued against a credit pool of DEPTH slots shared between
//   requests still outstanding at the memory and responses already buffered
//   for the host. Because of this, every ack is guaranteed space in the
//   response FIFO.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   cmd_valid/cmd_ready         host command handshake
//   cmd_we/sel/addr/wdata       command fields (we=1 write, sel = byte enables)
//   rsp_valid/rsp_ready         host response handshake
//   rsp_we, rsp_rdata           response type and read data (0 for writes)
//   mem_stb/we/sel/addr/wdata   registered memory request, stb is a 1-cycle pulse
//   mem_ack, mem_rdata          memory completion, one per strobe, in order
//   inflight                    requests issued and not yet acked
//   busy                        any request or response still in the block
//   err_ack                     sticky flag: ack arrived with nothing outstanding
`timescale 1ns/1ps
module exmem_initiator #(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       cmd_we,
   input  logic [3:0]                 cmd_sel,
   input  logic [31:0]                cmd_addr,
   input  logic [31:0]                cmd_wdata,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic                       rsp_we,
   output logic [31:0]                rsp_rdata,
   output logic                       mem_stb,
   output logic                       mem_we,
   output logic [3:0]                 mem_sel,
   output logic [31:0]                mem_addr,
   output logic [31:0]                mem_wdata,
   input  logic                       mem_ack,
   input  logic [31:0]                mem_rdata,
   output logic [$clog2(DEPTH+1)-1:0] inflight,
   output logic                       busy,
   output logic                       err_ack
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH-1)) return '0;
      else                   return p + 1'b1;
   endfunction

   logic [CW-1:0] fcount;
   logic [CW:0]   used;
   logic          accept;
   logic          ack_ok;
   logic          pop;

   // Expected-response-type FIFO; its occupancy always equals inflight.
   logic          tq [DEPTH];
   logic [PW-1:0] tq_wp, tq_rp;
   logic          exp_we;

   // Response FIFO.
   logic          rq_we   [DEPTH];
   logic [31:0]   rq_data [DEPTH];
   logic [PW-1:0] rq_wp, rq_rp;

   // Credit check works on registered counters only, so cmd_ready never
   // depends combinationally on cmd_valid.
   assign used      = {1'b0, inflight} + {1'b0, fcount};
   assign cmd_ready = (used < (CW+1)'(DEPTH)) && !rst;
   assign accept    = cmd_valid && cmd_ready;
   // An ack with nothing outstanding is flagged and otherwise ignored.
   assign ack_ok    = mem_ack && (inflight != '0);
   assign pop       = rsp_valid && rsp_ready;
   assign exp_we    = tq[tq_rp];

   assign rsp_valid = (fcount != '0);
   assign rsp_we    = rsp_valid && rq_we[rq_rp];
   assign rsp_rdata = rsp_valid ? rq_data[rq_rp] : '0;
   assign busy      = (inflight != '0) || (fcount != '0) || mem_stb;

   // ---- issue stage: command accepted -> registered memory request ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_stb   <= 1'b0;
         mem_we    <= 1'b0;
         mem_sel   <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_stb <= accept;
         if (accept) begin
            mem_we    <= cmd_we;
            mem_sel   <= cmd_sel;
            mem_addr  <= cmd_addr;
            mem_wdata <= cmd_wdata;
         end
      end
   end

   // ---- FIFO storage (data only, never reset) ----
   always_ff @(posedge clk) begin
      if (accept)
         tq[tq_wp] <= cmd_we;
      if (ack_ok) begin
         rq_we[rq_wp]   <= exp_we;
         rq_data[rq_wp] <= exp_we ? '0 : mem_rdata;
      end
   end

   // ---- completion stage: pointers, counters, error flag ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tq_wp    <= '0;
         tq_rp    <= '0;
         rq_wp    <= '0;
         rq_rp    <= '0;
         inflight <= '0;
         fcount   <= '0;
         err_ack  <= 1'b0;
      end else begin
         if (accept)
            tq_wp <= ptr_inc(tq_wp);
         if (ack_ok) begin
            tq_rp <= ptr_inc(tq_rp);
            rq_wp <= ptr_inc(rq_wp);
         end
         if (pop)
            rq_rp <= ptr_inc(rq_rp);

         case ({accept, ack_ok})
            2'b10:   inflight <= inflight + 1'b1;
            2'b01:   inflight <= inflight - 1'b1;
            default: ;
         endcase

         case ({ack_ok, pop})
            2'b10:   fcount <= fcount + 1'b1;
            2'b01:   fcount <= fcount - 1'b1;
            default: ;
         endcase

         if (mem_ack && (inflight == '0))
            err_ack <= 1'b1;
      end
   end

endmodule

// File: doc/exmem_initiator.md
EXMEM_INITIATOR -- requirements
Module: exmem_initiator

Interface
REQ-001 SHALL have parameter DEPTH, default 8: maximum number of issued-but-unreturned requests plus buffered responses; legal range 2..64.
REQ-002 SHALL have port clk, input, 1: clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have host command ports: cmd_valid in 1; cmd_ready out 1; cmd_we in 1 (1=write); cmd_sel in 4 (byte enables); cmd_addr in 32; cmd_wdata in 32.
REQ-005 SHALL have host response ports: rsp_valid out 1; rsp_ready in 1; rsp_we out 1 (response belongs to a write); rsp_rdata out 32.
REQ-006 SHALL have memory-side ports: mem_stb out 1; mem_we out 1; mem_sel out 4; mem_addr out 32; mem_wdata out 32; mem_ack in 1; mem_rdata in 32.
REQ-007 SHALL have status ports: inflight out clog2(DEPTH+1) (requests issued, not yet acked); busy out 1; err_ack out 1 (sticky).

Function
REQ-008 SHALL treat the memory as a fixed-but-unknown-latency, in-order, non-stallable responder: exactly one mem_ack pulse per mem_stb pulse, in issue order, no backpressure.
REQ-009 SHALL define credit = DEPTH - inflight - fcount, where fcount = response-FIFO occupancy.
REQ-010 SHALL drive cmd_ready = (credit != 0) && !rst, from registered state only (no combinational path from cmd_valid).
REQ-011 SHALL accept a command in cycle t when cmd_valid && cmd_ready; then in cycle t+1 mem_stb=1 for exactly one cycle, with mem_we/mem_sel/mem_addr/mem_wdata equal to the accepted cmd_* values.
REQ-012 SHALL register all mem_* outputs; with no accept in cycle t, mem_stb=0 in t+1 and other mem_* hold their last values.
REQ-013 SHALL sustain one accepted command per cycle while credit allows (back-to-back mem_stb pulses).
REQ-014 SHALL increment inflight on accept and decrement on mem_ack; simultaneous accept and ack leave it unchanged.
REQ-015 SHALL keep a DEPTH-entry FIFO of expected-response types (we bit) written on accept and read on mem_ack, so each response is tagged with the correct rsp_we.
REQ-016 SHALL push {expected we, mem_rdata} into a DEPTH-entry response FIFO on every valid mem_ack; write responses carry rsp_rdata=0.
REQ-017 SHALL drive rsp_valid = (fcount != 0), rsp_we/rsp_rdata = FIFO head; pop on rsp_valid && rsp_ready.
REQ-018 SHALL support push and pop in the same cycle, including at fcount=DEPTH-1 and fcount=1; fcount then unchanged.
REQ-019 SHALL guarantee by credit that the response FIFO never overflows; mem_ack therefore always finds space.
REQ-020 SHALL, on mem_ack with inflight=0, set err_ack=1 (sticky until reset), push nothing, and leave counters unchanged.
REQ-021 SHALL drive busy = (inflight != 0) || (fcount != 0) || mem_stb.
REQ-022 SHALL use wrap-around read/write pointers of width clog2(DEPTH) for both FIFOs; DEPTH not a power of two SHALL wrap at DEPTH-1 -> 0.

Reset
REQ-023 SHALL, while rst=1, force cmd_ready=0, rsp_valid=0, rsp_we=0, rsp_rdata=0, mem_stb=0, mem_we=0, mem_sel=0, mem_addr=0, mem_wdata=0, inflight=0, busy=0, err_ack=0, FIFO pointers and counts to 0.
REQ-024 SHALL, on reset mid-operation, discard all in-flight and buffered transactions with no responses produced; the attached memory SHALL share rst so no stale acks follow.
REQ-025 SHALL assert cmd_ready in the first clock cycle after rst deasserts.

Verification
REQ-026 Single write: cmd {we=1, sel=F, addr=0x10, wdata=0xDEADBEEF} accepted at t -> mem_stb=1 at t+1 with same fields; after ack, rsp_valid=1, rsp_we=1, rsp_rdata=0.
REQ-027 Read-back: write 0xA5A5A5A5 to 0x20 then read 0x20 with N=10 memory -> read rsp_rdata=0xA5A5A5A5, rsp_we=0, responses in issue order.
REQ-028 Credit limit: DEPTH=8, rsp_ready=0, 12 back-to-back reads -> exactly 8 accepted, cmd_ready=0 thereafter, fcount reaches 8, no loss; rsp_ready=1 drains 8 in order, then remaining 4 accepted.
REQ-029 Streaming: rsp_ready=1, 32 interleaved writes/reads -> one accept per cycle sustained, inflight never exceeds 8, every read returns last written data.
REQ-030 Spurious ack: mem_ack pulse with inflight=0 -> err_ack=1 and stays 1, rsp_valid stays 0, inflight stays 0.
REQ-031 Reset mid-burst: rst asserted with inflight=5, fcount=2 -> all outputs per REQ-023 immediately; after release cmd_ready=1 next cycle, no rsp_valid.
